// File: rtl/glb_to_dram_writer.sv
// Backward-transfer engine: reads words_num consecutive GLB words starting at
// base_addr, packs FIFO_WIDTH/DATA_WIDTH words per beat (first word in the LSB
// lane) and pushes the beats to the DRAM-side FIFO. Runs in the core_clk domain.
// Ports:
//   core_clk, reset            clock, synchronous active-high reset
//   start_backward             1-cycle start, sampled only in IDLE
//   base_addr, words_num       transfer descriptor, latched on start
//   glb_re/glb_raddr/glb_rdata GLB read port, data valid 1 cycle after glb_re
//   we_to_dram/wdata_to_dram   beat valid/data, transfer on we_to_dram & dram_ready
//   dram_ready                 DRAM FIFO not full
//   busy                       transfer in progress
//   back_transfer_done         1-cycle pulse after the final beat is accepted
module glb_to_dram_writer #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_WIDTH = 64
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  start_backward,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] words_num,
    output logic                  glb_re,
    output logic [ADDR_WIDTH-1:0] glb_raddr,
    input  logic [DATA_WIDTH-1:0] glb_rdata,
    output logic                  we_to_dram,
    output logic [FIFO_WIDTH-1:0] wdata_to_dram,
    input  logic                  dram_ready,
    output logic                  busy,
    output logic                  back_transfer_done
);

    localparam int unsigned PACK   = FIFO_WIDTH / DATA_WIDTH;
    localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, words_q, rd_cnt_q, wr_cnt_q;
    logic [LANE_W-1:0]     lane_q;
    logic                  rd_vld_q;
    logic [FIFO_WIDTH-1:0] pack_q;
    logic [FIFO_WIDTH-1:0] fifo_mem_q [2];
    logic                  fifo_wp_q, fifo_rp_q;
    logic [1:0]            fifo_cnt_q;

    logic                  start_c, last_word_c, last_issue_c, push_c, pop_c, throttle_c;
    logic [FIFO_WIDTH-1:0] beat_c;

    // Datapath decode: beat completion, FIFO handshakes, read throttle
    always_comb begin
        start_c      = (state_q == IDLE) && start_backward;
        last_word_c  = (wr_cnt_q == (words_q - ADDR_WIDTH'(1)));
        last_issue_c = (rd_cnt_q == (words_q - ADDR_WIDTH'(1)));
        // An arriving word closes a beat when it fills the top lane or is the final word
        push_c       = rd_vld_q && ((lane_q == LANE_W'(PACK - 1)) || last_word_c);
        pop_c        = we_to_dram && dram_ready;
        // Stop issuing if the 2-deep beat FIFO could overflow
        throttle_c   = (fifo_cnt_q == 2'd2) || ((fifo_cnt_q == 2'd1) && push_c);
        beat_c       = pack_q;
        beat_c[int'(lane_q) * int'(DATA_WIDTH) +: DATA_WIDTH] = glb_rdata;
    end

    // Outputs decoded from registered state
    always_comb begin
        glb_re             = (state_q == READ) && !throttle_c;
        glb_raddr          = glb_re ? (base_q + rd_cnt_q) : '0;
        we_to_dram         = (fifo_cnt_q != 2'd0);
        wdata_to_dram      = we_to_dram ? fifo_mem_q[fifo_rp_q] : '0;
        busy               = (state_q != IDLE);
        back_transfer_done = (state_q == DONE);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_backward) state_d = (words_num == '0) ? DONE : READ;
            READ:  if (glb_re && last_issue_c) state_d = DRAIN;
            // Done once no word is in flight and the last beat leaves the FIFO
            DRAIN: if (!rd_vld_q && ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop_c)))
                       state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge core_clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Counters, pack register and beat FIFO
    always_ff @(posedge core_clk) begin
        if (reset) begin
            base_q        <= '0;
            words_q       <= '0;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            lane_q        <= '0;
            rd_vld_q      <= 1'b0;
            pack_q        <= '0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_wp_q     <= 1'b0;
            fifo_rp_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            rd_vld_q <= glb_re;
            if (start_c) begin
                base_q   <= base_addr;
                words_q  <= words_num;
                rd_cnt_q <= '0;
                wr_cnt_q <= '0;
                lane_q   <= '0;
                pack_q   <= '0;
            end else begin
                if (glb_re) rd_cnt_q <= rd_cnt_q + ADDR_WIDTH'(1);
                if (rd_vld_q) begin
                    wr_cnt_q <= wr_cnt_q + ADDR_WIDTH'(1);
                    if (push_c) begin
                        lane_q <= '0;
                        pack_q <= '0;
                    end else begin
                        lane_q <= lane_q + LANE_W'(1);
                        pack_q <= beat_c;
                    end
                end
            end
            if (push_c) begin
                fifo_mem_q[fifo_wp_q] <= beat_c;
                fifo_wp_q             <= ~fifo_wp_q;
            end
            if (pop_c) fifo_rp_q <= ~fifo_rp_q;
            case ({push_c, pop_c})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule
